gnr_floyd_ctrl: RTL



---
 rtl/gnr_pkg.sv | 29 ++
 rtl/gnr_vec_cmp.sv | 22 ++
 rtl/gnr_floyd_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/gnr_pkg.sv
// -----------------------------------------------------------------------------
// gnr_pkg
// Shared definitions for the Boolean-network Floyd controller:
//   - default network width and counter width
//   - controller FSM state encoding
// -----------------------------------------------------------------------------
package gnr_pkg;

  localparam int GNR_N_NODES = 8;
  localparam int GNR_CNT_W   = 16;

  // IDLE   : waiting for a start request
  // INIT   : node array loads init_state (reset_nos high)
  // STEP   : one hare step, half a tortoise step
  // CHECK  : compare tortoise/hare after the step
  // PSTEP  : hare-only step while measuring the attractor period
  // PCHECK : compare hare against the captured attractor state
  // FIN    : publish results, return to IDLE
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    STEP   = 3'd2,
    CHECK  = 3'd3,
    PSTEP  = 3'd4,
    PCHECK = 3'd5,
    FIN    = 3'd6
  } gnr_state_e;

endpackage

// File: rtl/gnr_vec_cmp.sv
// -----------------------------------------------------------------------------
// gnr_vec_cmp
// Purely combinational N_NODES-bit equality comparator. The controller muxes
// its operands so one instance serves both the tortoise/hare meet test and
// the period test.
//   a_i  : first state vector
//   b_i  : second state vector
//   eq_o : 1 when a_i == b_i
// -----------------------------------------------------------------------------
module gnr_vec_cmp
  import gnr_pkg::*;
#(
  parameter int N_NODES = GNR_N_NODES
) (
  input  logic [N_NODES-1:0] a_i,
  input  logic [N_NODES-1:0] b_i,
  output logic               eq_o
);

  assign eq_o = (a_i == b_i);

endmodule

// File: rtl/gnr_floyd_ctrl.sv
// -----------------------------------------------------------------------------
// gnr_floyd_ctrl
// Initiator-side controller for a Boolean-network node array. It loads an
// initial state into the nodes, steps the tortoise (s0) and hare (s1)
// trajectories until they meet (Floyd cycle detection), then steps the hare
// alone to measure the attractor period.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   start           : one-cycle run request, ignored while busy
//   init_vec        : initial network state, sampled on an accepted start
//   s0_vec, s1_vec  : tortoise / hare state vectors read back from the nodes
//   reset_nos       : node state-load strobe
//   init_state      : per-node initial value driven to the array
//   start_s0        : tortoise step strobe (nodes advance every 2nd strobe)
//   start_s1        : hare step strobe
//   busy            : run in progress
//   done            : results valid, held until the next accepted start
//   timeout         : run aborted at MAX_STEPS (valid with done)
//   meet_steps      : tortoise index i at which x_i == x_2i
//   period          : attractor cycle length
//   attractor_state : hare state captured at the meet
//
// Every output is a register. The strobes are registered from the next-state
// decision, so a strobe is high exactly while the FSM sits in STEP/PSTEP and
// the node outputs reflect the step in the following CHECK/PCHECK cycle.
// -----------------------------------------------------------------------------
module gnr_floyd_ctrl
  import gnr_pkg::*;
#(
  parameter int               N_NODES   = GNR_N_NODES,
  parameter int               CNT_W     = GNR_CNT_W,
  parameter logic [CNT_W-1:0] MAX_STEPS = 16'hFFFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_NODES-1:0] init_vec,
  input  logic [N_NODES-1:0] s0_vec,
  input  logic [N_NODES-1:0] s1_vec,
  output logic               reset_nos,
  output logic [N_NODES-1:0] init_state,
  output logic               start_s0,
  output logic               start_s1,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [CNT_W-1:0]   meet_steps,
  output logic [CNT_W-1:0]   period,
  output logic [N_NODES-1:0] attractor_state
);

  gnr_state_e         state_q, state_d;
  logic [N_NODES-1:0] init_state_q, init_state_d;
  logic               reset_nos_q, reset_nos_d;
  logic               start_s0_q, start_s0_d;
  logic               start_s1_q, start_s1_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   meet_q, meet_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [N_NODES-1:0] attr_q, attr_d;
  logic [CNT_W-1:0]   hare_cnt_q, hare_cnt_d;
  logic [CNT_W-1:0]   period_cnt_q, period_cnt_d;

  // Shared comparator: in PCHECK the hare is compared against the captured
  // attractor; in every other state the operand is the tortoise vector, which
  // is only acted upon in CHECK.
  logic [N_NODES-1:0] cmp_a;
  logic               vec_eq;

  assign cmp_a = (state_q == PCHECK) ? attr_q : s0_vec;

  gnr_vec_cmp #(
    .N_NODES (N_NODES)
  ) u_cmp (
    .a_i  (cmp_a),
    .b_i  (s1_vec),
    .eq_o (vec_eq)
  );

  // Next-state and output decisions
  always_comb begin
    state_d      = state_q;
    init_state_d = init_state_q;
    reset_nos_d  = 1'b0;
    start_s0_d   = 1'b0;
    start_s1_d   = 1'b0;
    busy_d       = busy_q;
    done_d       = done_q;
    timeout_d    = timeout_q;
    meet_d       = meet_q;
    period_d     = period_q;
    attr_d       = attr_q;
    hare_cnt_d   = hare_cnt_q;
    period_cnt_d = period_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          init_state_d = init_vec;
          done_d       = 1'b0;
          timeout_d    = 1'b0;
          meet_d       = '0;
          period_d     = '0;
          attr_d       = '0;
          hare_cnt_d   = '0;
          period_cnt_d = '0;
          busy_d       = 1'b1;
          reset_nos_d  = 1'b1;
          state_d      = INIT;
        end
      end

      INIT: begin
        start_s0_d = 1'b1;
        start_s1_d = 1'b1;
        state_d    = STEP;
      end

      STEP: begin
        hare_cnt_d = hare_cnt_q + 1'b1;
        state_d    = CHECK;
      end

      CHECK: begin
        // At odd hare counts the tortoise is half-way through its step, so
        // the vectors are only meaningful to compare at even counts.
        if (!hare_cnt_q[0] && vec_eq) begin
          meet_d       = hare_cnt_q >> 1;
          attr_d       = s1_vec;
          period_cnt_d = '0;
          start_s1_d   = 1'b1;
          state_d      = PSTEP;
        end else if (hare_cnt_q == MAX_STEPS) begin
          timeout_d = 1'b1;
          state_d   = FIN;
        end else begin
          start_s0_d = 1'b1;
          start_s1_d = 1'b1;
          state_d    = STEP;
        end
      end

      PSTEP: begin
        period_cnt_d = period_cnt_q + 1'b1;
        state_d      = PCHECK;
      end

      PCHECK: begin
        if (vec_eq) begin
          period_d = period_cnt_q;
          state_d  = FIN;
        end else if (period_cnt_q == MAX_STEPS) begin
          timeout_d = 1'b1;
          state_d   = FIN;
        end else begin
          start_s1_d = 1'b1;
          state_d    = PSTEP;
        end
      end

      FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      init_state_q <= '0;
      reset_nos_q  <= 1'b0;
      start_s0_q   <= 1'b0;
      start_s1_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      meet_q       <= '0;
      period_q     <= '0;
      attr_q       <= '0;
      hare_cnt_q   <= '0;
      period_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      init_state_q <= init_state_d;
      reset_nos_q  <= reset_nos_d;
      start_s0_q   <= start_s0_d;
      start_s1_q   <= start_s1_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      meet_q       <= meet_d;
      period_q     <= period_d;
      attr_q       <= attr_d;
      hare_cnt_q   <= hare_cnt_d;
      period_cnt_q <= period_cnt_d;
    end
  end

  assign reset_nos       = reset_nos_q;
  assign init_state      = init_state_q;
  assign start_s0        = start_s0_q;
  assign start_s1        = start_s1_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign timeout         = timeout_q;
  assign meet_steps      = meet_q;
  assign period          = period_q;
  assign attractor_state = attr_q;

endmodule
